// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle RV32I control unit.
// A Moore FSM sequences the shared-memory datapath (PC, OldPC, IR, A/B,
// ALUOut, MDR). It handles the memory-ready handshake with a wait timeout,
// illegal-instruction trapping, and a one-cycle retire pulse.
module rv_multicycle_ctrl #(
    parameter int ALU_CTRL_W      = 4,
    parameter int MEM_TIMEOUT     = 64,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            imm_src,
    output logic                  instr_done,
    output logic                  illegal_instr,
    output logic                  mem_timeout
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam int               CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
        S_JALR_JUMP, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       alu_sel;
    logic             illegal;
    logic             taken;
    logic             waiting;
    logic             timed_out;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign alu_control       = ALU_CTRL_W'(alu_sel);

    // Shared R/I operation table; funct7[5] selects SUB/SRA (callers mask it for OP-IMM ADD).
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // A memory-access state stalls while mem_ready is low. The access times out
    // once the counter already holds MEM_TIMEOUT and memory is still not ready,
    // so a ready arriving in the limit cycle completes normally.
    assign waiting   = (state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE) && !mem_ready;
    assign timed_out = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == CNT_LIMIT);

    // Opcode legality check plus branch-taken evaluation from the ALU flags.
    always_comb begin
        illegal = 1'b0;
        taken   = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal = 1'b0;
            OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
            default:   illegal = 1'b1;
        endcase
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Wait counter restarts on every state change and counts stalled cycles; sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            if (state_next != state)             wait_cnt <= '0;
            else if (waiting && wait_cnt != '1)  wait_cnt <= wait_cnt + 1'b1;
            if (state == S_DECODE && illegal && TRAP_ON_ILLEGAL) illegal_instr <= 1'b1;
            if (timed_out)                                       mem_timeout   <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (timed_out) state_next = S_TRAP; else if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (illegal) state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                        OP_R:              state_next = S_EXEC_R;
                        OP_I:              state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADR:   state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (timed_out) state_next = S_TRAP; else if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WRITE: if (timed_out) state_next = S_TRAP; else if (mem_ready) state_next = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL, S_JALR_JUMP: state_next = S_ALU_WB;
            S_JALR:      state_next = S_JALR_JUMP;
            S_TRAP:      state_next = S_TRAP;
            default:     state_next = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode every cycle.
    always_comb begin
        case (opcode)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    // Per-state outputs; everything stays low while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_sel    = ALU_ADD;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                    ir_write = mem_ready; pc_write = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01; alu_src_b = 2'b01;
                    instr_done = illegal && !TRAP_ON_ILLEGAL;
                end
                S_MEM_ADR, S_JALR: begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
                S_MEM_READ:  begin mem_req = 1'b1; adr_src = 1'b1; end
                S_MEM_WB:    begin result_src = 2'b01; reg_write = 1'b1; instr_done = 1'b1; end
                S_MEM_WRITE: begin
                    mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1; instr_done = mem_ready;
                end
                S_EXEC_R:    begin alu_src_a = 2'b10; alu_sel = alu_op(funct3, funct7_5); end
                S_EXEC_I: begin
                    alu_src_a = 2'b10; alu_src_b = 2'b01;
                    alu_sel   = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
                end
                S_ALU_WB:    begin reg_write = 1'b1; instr_done = 1'b1; end
                S_BRANCH: begin
                    alu_src_a = 2'b10; alu_sel = ALU_SUB; instr_done = 1'b1; pc_write = taken;
                end
                S_JAL, S_JALR_JUMP: begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
                S_LUI:       begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
                S_AUIPC:     begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Testbench for rv_multicycle_ctrl. Each instruction is expanded into the
// per-cycle output sequence implied by its class, and those expected cycles
// are checked against two DUT configurations.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;
    typedef struct {
        bit rst; logic [31:0] instr; bit zero; bit lt; bit ltu; bit rdy;
        int mem_req; int mem_write; int adr_src; int ir_write; int pc_write; int reg_write;
        int result_src; int src_a; int src_b; int alu; int imm; int done; int ill; int tmo;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default timeout, traps illegal instructions
    logic a_reset, a_zero, a_lt, a_ltu, a_rdy;
    logic [31:0] a_instr;
    logic a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_result_src, a_src_a, a_src_b;
    logic [3:0] a_alu;
    logic [2:0] a_imm;
    logic a_done, a_ill, a_tmo;
    // DUT B: short timeout, illegal retired as NOP, wide alu_control
    logic b_reset, b_zero, b_lt, b_ltu, b_rdy;
    logic [31:0] b_instr;
    logic b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_result_src, b_src_a, b_src_b;
    logic [5:0] b_alu;
    logic [2:0] b_imm;
    logic b_done, b_ill, b_tmo;

    rv_multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_TIMEOUT(64), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(a_reset), .instr(a_instr), .zero(a_zero), .lt(a_lt), .ltu(a_ltu),
        .mem_ready(a_rdy), .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .result_src(a_result_src), .alu_src_a(a_src_a), .alu_src_b(a_src_b),
        .alu_control(a_alu), .imm_src(a_imm), .instr_done(a_done),
        .illegal_instr(a_ill), .mem_timeout(a_tmo));

    rv_multicycle_ctrl #(.ALU_CTRL_W(6), .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(b_reset), .instr(b_instr), .zero(b_zero), .lt(b_lt), .ltu(b_ltu),
        .mem_ready(b_rdy), .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .result_src(b_result_src), .alu_src_a(b_src_a), .alu_src_b(b_src_b),
        .alu_control(b_alu), .imm_src(b_imm), .instr_done(b_done),
        .illegal_instr(b_ill), .mem_timeout(b_tmo));

    int total = 0;
    int bad   = 0;

    step_t bq[$];
    step_t qa[$];
    step_t qb[$];
    logic [31:0] g_instr;
    bit g_zero, g_lt, g_ltu, g_trap_ill, g_ill, g_tmo, g_dead;
    int g_lim;

    task automatic cmp(input string name, input int act, input int exp);
        if (exp < 0) return;
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return 0;
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b1101111: return 3;
            7'b0110111, 7'b0010111: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            7'b1100011: return !(ins[14:12] == 3'd2 || ins[14:12] == 3'd3);
            default: return 1'b0;
        endcase
    endfunction

    // ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9
    function automatic int alu_for(input logic [2:0] f3, input bit alt);
        int tbl[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (f3 == 3'd0 && alt) return 1;
        if (f3 == 3'd5 && alt) return 9;
        return tbl[f3];
    endfunction

    function automatic int branch_taken(input logic [2:0] f3);
        case (f3)
            3'd0: return int'(g_zero);
            3'd1: return int'(!g_zero);
            3'd4: return int'(g_lt);
            3'd5: return int'(!g_lt);
            3'd6: return int'(g_ltu);
            default: return int'(!g_ltu);
        endcase
    endfunction

    function automatic step_t mk(input bit rdy);
        step_t s;
        s.rst = 1'b1; s.instr = g_instr; s.zero = g_zero; s.lt = g_lt; s.ltu = g_ltu; s.rdy = rdy;
        s.mem_req = 0; s.mem_write = 0; s.adr_src = -1; s.ir_write = 0; s.pc_write = 0;
        s.reg_write = 0; s.result_src = -1; s.src_a = -1; s.src_b = -1; s.alu = -1;
        s.imm = exp_imm(g_instr); s.done = 0; s.ill = int'(g_ill); s.tmo = int'(g_tmo);
        return s;
    endfunction

    function automatic step_t sel(input int a, input int b, input int alu);
        step_t s;
        s = mk(1'b1); s.src_a = a; s.src_b = b; s.alu = alu;
        return s;
    endfunction

    task automatic reset_cycles(input int n);
        step_t s;
        g_ill = 1'b0; g_tmo = 1'b0; g_dead = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = mk(1'b1); s.rst = 1'b0; bq.push_back(s);
        end
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) bq.push_back(mk(1'b1));
    endtask

    task automatic push_wb();
        step_t s;
        s = mk(1'b1); s.result_src = 0; s.reg_write = 1; s.done = 1; bq.push_back(s);
    endtask

    // kind: 0 instruction fetch, 1 data read, 2 data write
    task automatic mem_access(input int kind, input int waits, output bit ok);
        step_t s;
        ok = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            s = mk(i >= waits);
            s.mem_req = 1;
            if (kind == 0) begin
                s.adr_src = 0; s.src_a = 0; s.src_b = 2; s.alu = 0; s.result_src = 2;
            end else begin
                s.adr_src = 1; s.mem_write = (kind == 2) ? 1 : 0;
            end
            if (i >= waits) begin
                if (kind == 0) begin s.ir_write = 1; s.pc_write = 1; end
                if (kind == 2) s.done = 1;
                bq.push_back(s); ok = 1'b1;
                return;
            end
            bq.push_back(s);
            if (g_lim > 0 && i == g_lim) begin
                g_tmo = 1'b1; g_dead = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input bit z, input bit l, input bit lu);
        step_t s;
        bit ok;
        logic [2:0] f3;
        g_instr = ins; g_zero = z; g_lt = l; g_ltu = lu;
        f3 = ins[14:12];
        mem_access(0, fw, ok);
        if (!ok) return;
        s = sel(1, 1, 0);
        if (!legal(ins)) begin
            if (g_trap_ill) begin bq.push_back(s); g_ill = 1'b1; g_dead = 1'b1; end
            else begin s.done = 1; bq.push_back(s); end
            return;
        end
        bq.push_back(s);
        case (ins[6:0])
            7'b0000011: begin
                bq.push_back(sel(2, 1, 0));
                mem_access(1, mw, ok);
                if (ok) begin
                    s = mk(1'b1); s.result_src = 1; s.reg_write = 1; s.done = 1; bq.push_back(s);
                end
            end
            7'b0100011: begin bq.push_back(sel(2, 1, 0)); mem_access(2, mw, ok); end
            7'b0110011: begin bq.push_back(sel(2, 0, alu_for(f3, ins[30]))); push_wb(); end
            7'b0010011: begin
                bq.push_back(sel(2, 1, (f3 == 3'd0) ? 0 : alu_for(f3, ins[30]))); push_wb();
            end
            7'b1100011: begin
                s = sel(2, 0, 1); s.result_src = 0; s.done = 1; s.pc_write = branch_taken(f3);
                bq.push_back(s);
            end
            7'b1101111: begin
                s = sel(1, 2, 0); s.result_src = 0; s.pc_write = 1; bq.push_back(s); push_wb();
            end
            7'b1100111: begin
                bq.push_back(sel(2, 1, 0));
                s = sel(1, 2, 0); s.result_src = 0; s.pc_write = 1; bq.push_back(s); push_wb();
            end
            7'b0110111: begin bq.push_back(sel(3, 1, 0)); push_wb(); end
            default:    begin bq.push_back(sel(1, 1, 0)); push_wb(); end
        endcase
    endtask

    // ---------------- DUT access ----------------
    task automatic drive_a(input step_t s);
        a_reset = s.rst; a_instr = s.instr; a_zero = s.zero; a_lt = s.lt; a_ltu = s.ltu; a_rdy = s.rdy;
    endtask

    task automatic drive_b(input step_t s);
        b_reset = s.rst; b_instr = s.instr; b_zero = s.zero; b_lt = s.lt; b_ltu = s.ltu; b_rdy = s.rdy;
    endtask

    function automatic step_t sample_a();
        step_t s;
        s = mk(1'b0);
        s.mem_req = int'(a_mem_req); s.mem_write = int'(a_mem_write); s.adr_src = int'(a_adr_src);
        s.ir_write = int'(a_ir_write); s.pc_write = int'(a_pc_write); s.reg_write = int'(a_reg_write);
        s.result_src = int'(a_result_src); s.src_a = int'(a_src_a); s.src_b = int'(a_src_b);
        s.alu = int'(a_alu); s.imm = int'(a_imm); s.done = int'(a_done);
        s.ill = int'(a_ill); s.tmo = int'(a_tmo);
        return s;
    endfunction

    function automatic step_t sample_b();
        step_t s;
        s = mk(1'b0);
        s.mem_req = int'(b_mem_req); s.mem_write = int'(b_mem_write); s.adr_src = int'(b_adr_src);
        s.ir_write = int'(b_ir_write); s.pc_write = int'(b_pc_write); s.reg_write = int'(b_reg_write);
        s.result_src = int'(b_result_src); s.src_a = int'(b_src_a); s.src_b = int'(b_src_b);
        s.alu = int'(b_alu); s.imm = int'(b_imm); s.done = int'(b_done);
        s.ill = int'(b_ill); s.tmo = int'(b_tmo);
        return s;
    endfunction

    task automatic check_step(input string who, input int idx, input step_t e, input step_t a);
        string p;
        p = $sformatf("%s[%0d]", who, idx);
        cmp({p, ".mem_req"},    a.mem_req,    e.mem_req);
        cmp({p, ".mem_write"},  a.mem_write,  e.mem_write);
        cmp({p, ".adr_src"},    a.adr_src,    e.adr_src);
        cmp({p, ".ir_write"},   a.ir_write,   e.ir_write);
        cmp({p, ".pc_write"},   a.pc_write,   e.pc_write);
        cmp({p, ".reg_write"},  a.reg_write,  e.reg_write);
        cmp({p, ".result_src"}, a.result_src, e.result_src);
        cmp({p, ".alu_src_a"},  a.src_a,      e.src_a);
        cmp({p, ".alu_src_b"},  a.src_b,      e.src_b);
        cmp({p, ".alu_control"},a.alu,        e.alu);
        cmp({p, ".imm_src"},    a.imm,        e.imm);
        cmp({p, ".instr_done"}, a.done,       e.done);
        cmp({p, ".illegal"},    a.ill,        e.ill);
        cmp({p, ".timeout"},    a.tmo,        e.tmo);
    endtask

    int n0, ia, ib, cnt;
    bit ha, hb;
    step_t sa, sb;

    initial begin
        a_reset = 1'b0; a_instr = '0; a_zero = 1'b0; a_lt = 1'b0; a_ltu = 1'b0; a_rdy = 1'b0;
        b_reset = 1'b0; b_instr = '0; b_zero = 1'b0; b_lt = 1'b0; b_ltu = 1'b0; b_rdy = 1'b0;
        g_instr = 32'h002081B3; g_zero = 1'b0; g_lt = 1'b0; g_ltu = 1'b0;

        // ----- program for DUT A -----
        g_lim = 64; g_trap_ill = 1'b1; bq.delete();
        reset_cycles(3);
        n0 = bq.size(); run_instr(32'h002081B3, 0, 0, 0, 0, 0);       // add
        cmp("pin.add_len", bq.size() - n0, 4);
        cmp("pin.add_wb_done", bq[n0 + 3].done, 1);
        run_instr(32'h402081B3, 0, 0, 0, 0, 0);                       // sub
        n0 = bq.size(); run_instr(32'h4020D1B3, 0, 0, 0, 0, 0);       // sra
        cmp("pin.sra_alu", bq[n0 + 2].alu, 9);
        run_instr(32'h0020D1B3, 0, 0, 0, 0, 0);                       // srl
        run_instr(32'h0020B1B3, 0, 0, 0, 0, 0);                       // sltu
        run_instr(32'h0020A1B3, 0, 0, 0, 0, 0);                       // slt
        run_instr(32'h002091B3, 0, 0, 0, 0, 0);                       // sll
        run_instr(32'h0020C1B3, 0, 0, 0, 0, 0);                       // xor
        run_instr(32'h0020E1B3, 0, 0, 0, 0, 0);                       // or
        run_instr(32'h0020F1B3, 0, 0, 0, 0, 0);                       // and
        run_instr(32'h00108093, 0, 0, 0, 0, 0);                       // addi
        run_instr(32'h40008093, 0, 0, 0, 0, 0);                       // addi, imm bit 30 set
        run_instr(32'h4010D093, 0, 0, 0, 0, 0);                       // srai
        run_instr(32'h0010C093, 0, 0, 0, 0, 0);                       // xori
        n0 = bq.size(); run_instr(32'h0000A183, 0, 5, 0, 0, 0);       // lw, 5 stall cycles
        cmp("pin.lw_len", bq.size() - n0, 10);
        cnt = 0;
        for (int i = n0; i < bq.size(); i++) if (bq[i].adr_src == 1) cnt++;
        cmp("pin.lw_read_cycles", cnt, 6);
        cmp("pin.lw_wb_src", bq[bq.size() - 1].result_src, 1);
        run_instr(32'h0020A023, 1, 2, 0, 0, 0);                       // sw
        n0 = bq.size(); run_instr(32'h0020E063, 0, 0, 0, 0, 1);       // bltu, ltu=1
        cmp("pin.bltu_len", bq.size() - n0, 3);
        cmp("pin.bltu_taken", bq[n0 + 2].pc_write, 1);
        n0 = bq.size(); run_instr(32'h0020F063, 0, 0, 0, 0, 1);       // bgeu, ltu=1
        cmp("pin.bgeu_taken", bq[n0 + 2].pc_write, 0);
        run_instr(32'h00208063, 0, 0, 1, 0, 0);                       // beq zero=1
        run_instr(32'h00209063, 0, 0, 1, 0, 0);                       // bne zero=1
        run_instr(32'h0020C063, 0, 0, 0, 1, 0);                       // blt lt=1
        run_instr(32'h0020D063, 0, 0, 0, 0, 0);                       // bge lt=0
        run_instr(32'h008000EF, 0, 0, 0, 0, 0);                       // jal
        n0 = bq.size(); run_instr(32'h000280E7, 0, 0, 0, 0, 0);       // jalr
        cmp("pin.jalr_len", bq.size() - n0, 5);
        run_instr(32'h123450B7, 0, 0, 0, 0, 0);                       // lui
        run_instr(32'h00001097, 0, 0, 0, 0, 0);                       // auipc
        run_instr(32'h0000007F, 0, 0, 0, 0, 0);                       // illegal opcode
        trap_cycles(3);
        cmp("pin.trap_ill", bq[bq.size() - 1].ill, 1);
        reset_cycles(2);
        run_instr(32'h0020A063, 0, 0, 0, 0, 0);                       // branch funct3 010
        trap_cycles(2);
        reset_cycles(2);
        n0 = bq.size(); run_instr(32'h0000A183, 0, 3, 0, 0, 0);       // lw aborted in MEM_READ
        while (bq.size() > n0 + 4) void'(bq.pop_back());
        reset_cycles(2);
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);
        qa = bq;

        // ----- program for DUT B -----
        g_lim = 4; g_trap_ill = 1'b0; bq.delete();
        reset_cycles(3);
        run_instr(32'h002081B3, 4, 0, 0, 0, 0);                       // ready exactly at the limit
        run_instr(32'h0000A183, 0, 4, 0, 0, 0);                       // lw, ready at the limit
        n0 = bq.size(); run_instr(32'h0000007F, 0, 0, 0, 0, 0);       // illegal retired as NOP
        cmp("pin.nop_len", bq.size() - n0, 2);
        cmp("pin.nop_done", bq[n0 + 1].done, 1);
        run_instr(32'h40008093, 0, 0, 0, 0, 0);
        n0 = bq.size(); run_instr(32'h002081B3, 100, 0, 0, 0, 0);     // fetch timeout
        cmp("pin.fetch_timeout_len", bq.size() - n0, 5);
        trap_cycles(3);
        cmp("pin.fetch_timeout_flag", bq[bq.size() - 1].tmo, 1);
        reset_cycles(2);
        run_instr(32'h0020D063, 0, 0, 0, 1, 0);                       // bge lt=1 -> not taken
        run_instr(32'h0020A023, 0, 100, 0, 0, 0);                     // store timeout
        trap_cycles(2);
        reset_cycles(2);
        run_instr(32'h4020D1B3, 0, 0, 0, 0, 0);
        qb = bq;

        // ----- drive and compare every cycle -----
        ia = 0; ib = 0;
        while (qa.size() > 0 || qb.size() > 0) begin
            @(posedge clk); #1;
            ha = qa.size() > 0;
            hb = qb.size() > 0;
            if (ha) begin sa = qa.pop_front(); drive_a(sa); end else a_reset = 1'b0;
            if (hb) begin sb = qb.pop_front(); drive_b(sb); end else b_reset = 1'b0;
            @(negedge clk);
            if (ha) begin check_step("A", ia, sa, sample_a()); ia++; end
            if (hb) begin check_step("B", ib, sb, sample_b()); ib++; end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
